lstm_gate_accum: RTL

Downstream accumulation stage for the LSTM gate datapath. Consumes the stream of 16-bit signed Q4.12 products from the gate multipliers, sums `N_TERMS` consecutive products plus one bias per vector, and saturates the sum back to 16-bit Q4.12. It emits one pre-activation value per vector over a valid/ready handshake to the activation stage.

---
 rtl/lstm_fx_pkg.sv | 16 +
 rtl/lstm_gate_accum_if.sv | 23 ++
 rtl/fx_saturate.sv | 32 +++
 rtl/lstm_gate_accum.sv | 127 ++++++++++++
 4 files changed

// File: rtl/lstm_fx_pkg.sv
// Fixed-point constants and shared types for the LSTM gate datapath.
package lstm_fx_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 12;

    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } accum_state_t;

endpackage

// File: rtl/lstm_gate_accum_if.sv
// Product stream in, pre-activation result out, both valid/ready.
interface lstm_gate_accum_if;
    import lstm_fx_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_prod;
    logic [DATA_W-1:0] in_bias;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sat;

    modport slave (
        input  in_valid, in_prod, in_bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_prod, in_bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fx_saturate.sv
// Clips a wide two's complement accumulator to 16-bit Q4.12 and flags the clip.
module fx_saturate
    import lstm_fx_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0]  din,
    output logic [DATA_W-1:0] dout,
    output logic              sat
);

    if (ACC_W <= DATA_W) begin : g_bad_width
        $error("fx_saturate: ACC_W must exceed DATA_W");
    end

    localparam logic [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W){1'b0}}, Q_MAX};
    localparam logic [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W){1'b1}}, Q_MIN};

    // Range compare against the Q4.12 limits
    always_comb begin
        dout = din[DATA_W-1:0];
        sat  = 1'b0;
        if ($signed(din) > $signed(MAX_V)) begin
            dout = Q_MAX;
            sat  = 1'b1;
        end else if ($signed(din) < $signed(MIN_V)) begin
            dout = Q_MIN;
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/lstm_gate_accum.sv
// Sums N_TERMS Q4.12 products plus a bias per vector and emits the
// saturated pre-activation value.
//
//   state | meaning
//   IDLE  | waiting for first beat (bias + product)
//   ACCUM | adding remaining products, gaps allowed
//   OUT   | result held on out_valid until out_ready
module lstm_gate_accum
    import lstm_fx_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    lstm_gate_accum_if.slave  bus,
    output logic              busy
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    if (N_TERMS < 1) begin : g_bad_terms
        $error("lstm_gate_accum: N_TERMS must be >= 1");
    end
    if (ACC_W < DATA_W + CNT_W) begin : g_bad_acc
        $error("lstm_gate_accum: ACC_W too narrow for N_TERMS");
    end

    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] x);
        return {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
    endfunction

    accum_state_t      state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_out;
    logic              beat;
    logic              in_ready_int;
    logic [DATA_W-1:0] sat_data;
    logic              sat_flag;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_sat_q;

    assign in_ready_int = (state_q != OUT);
    assign beat         = bus.in_valid && in_ready_int;

    // The saturator looks at the next accumulator value so the result can be
    // registered on the same edge that enters OUT.
    fx_saturate #(.ACC_W(ACC_W)) u_sat (
        .din  (acc_d),
        .dout (sat_data),
        .sat  (sat_flag)
    );

    // Next-state, accumulator and counter update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d = sext(bus.in_bias) + sext(bus.in_prod);
                    cnt_d = CNT_W'(1);
                    if (N_TERMS == 1) begin
                        state_d  = OUT;
                        load_out = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = acc_q + sext(bus.in_prod);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_TERMS - 1)) begin
                        state_d  = OUT;
                        load_out = 1'b1;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, datapath and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (state_d == OUT);
            if (load_out) begin
                out_data_q <= sat_data;
                out_sat_q  <= sat_flag;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign busy          = (state_q != IDLE);

endmodule
